mem_preload_ctrl: RTL
=====================

Name: mem_preload_ctrl

Overview:
Upstream loader for the 128x52 operand memory that feeds the 26-bit CSA multiplier loop. It accepts 26-bit operand pairs over a valid/ready stream and packs each pair into one 52-bit word. It writes the words to consecutive addresses 0..DEPTH-1 using the memory's active-low NCE/NWRT strobes, then raises done so the compute controller can take over the memory.

Parameters:
OP_W, 26, operand width; memory word is 2*OP_W.
DEPTH, 128, number of words loaded per run.
ADDR_W, 7, word address width; ADDR_W = RA_W + CA_W.
RA_W, 5, row-address width (upper address bits).
CA_W, 2, column-address width (lower address bits).

Ports:
clk  in  1  clock; all state updates on rising edge.
rstn  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle pulse; begins a load run from IDLE or DONE.
op_a  in  OP_W  upper operand; written to DIN[2*OP_W-1:OP_W].
op_b  in  OP_W  lower operand; written to DIN[OP_W-1:0].
in_valid  in  1  op_a/op_b valid.
in_ready  out  1  block can accept a pair this cycle.
DIN  out  2*OP_W  memory write data.
RA  out  RA_W  memory row address; equals addr[ADDR_W-1:CA_W].
CA  out  CA_W  memory column address; equals addr[CA_W-1:0].
NCE  out  1  memory chip enable, active-low.
NWRT  out  1  memory write enable, active-low.
busy  out  1  a load run is in progress.
done  out  1  all DEPTH words have been written; held high.
wr_count  out  ADDR_W+1  number of words written in the current run.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - NCE=1, NWRT=1, DIN=0, RA=0, CA=0, in_ready=0, busy=0, done=0, wr_count=0.
  - Input buffer emptied; accepted count=0; state=IDLE.
- All outputs are registered.
- States: IDLE, FETCH, SETUP, STROBE, HOLD, DONE.
- IDLE/DONE, start=1: next state FETCH; busy=1, done=0; wr_count, accepted count and addr cleared. In any other state, start is ignored.
- Input buffer: 2-entry FIFO.
  - in_ready = busy && FIFO not full && accepted_count < DEPTH.
  - A pair is accepted on an edge where in_valid && in_ready.
  - Simultaneous push and pop allowed; occupancy is then unchanged.
  - Pairs offered when in_ready=0 are not accepted; the producer must hold them.
- FETCH: if FIFO is non-empty, pop the head. DIN <= {op_a, op_b}; {RA, CA} <= addr; go to SETUP. Otherwise stay in FETCH with NCE=1, NWRT=1.
- SETUP: NCE=1, NWRT=1; address and data stable. Go to STROBE.
- STROBE: NCE=0, NWRT=0 for exactly one cycle; the memory captures the word on the following rising edge. Go to HOLD.
- HOLD: NCE=1, NWRT=1; DIN, RA and CA unchanged. wr_count += 1, addr += 1. If the new wr_count == DEPTH go to DONE, else go to FETCH.
- Steady-state throughput: one word per 4 cycles.
- First NCE low comes 3 cycles after the edge that accepts the first pair into an empty FIFO.
- DONE: busy=0, done=1, in_ready=0, NCE=1, NWRT=1. RA/CA hold the last address (DEPTH-1). No wrap to address 0 without a new start.
- NCE=0 is never driven with NWRT=1; this block never issues memory reads.
- Accepted pair order equals write address order.

Test Plan:
- Reset mid-STROBE: assert rstn while NCE=0 -> NCE=1 and NWRT=1 in the same cycle, with no clock edge; busy=0, wr_count=0. After release and start, the first write goes to address 0.
- Single pair: start, then op_a=26'h0000003, op_b=26'h0000005 -> exactly one NCE=0/NWRT=0 cycle with DIN=52'h0000000C000005, RA=0, CA=0. wr_count becomes 1; busy stays 1.
- Full run: in_valid held high, op_a=i, op_b=i+1 for i=0..127 -> 128 strobes, one every 4 cycles. Address i holds {i, i+1}; the last write has RA=31, CA=3. done=1 and wr_count=128. No further strobe occurs even while in_valid stays high; in_ready=0.
- Backpressure: producer pushes every cycle -> in_ready drops once 2 pairs are buffered. No pair is lost or duplicated; memory contents match send order.
- Sparse input: in_valid high one cycle in every 10 -> FSM waits in FETCH with NCE=1. Each pair is still written 3 cycles after its acceptance.
- start while busy: pulse start at wr_count=5 -> ignored; the run continues to address 5 without restarting. start in DONE -> done=0, busy=1, next write goes to address 0.

Source files
------------

// File: rtl/mem_preload_ctrl.sv
//==============================================================================
// Module      : mem_preload_ctrl
// Description : Streams 26-bit operand pairs into the 128x52 operand memory.
//               Each accepted pair is packed as {op_a, op_b} and written to
//               consecutive addresses with active-low NCE/NWRT strobes using a
//               FETCH/SETUP/STROBE/HOLD sequence. done then hands the memory
//               over to the compute controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_preload_ctrl #(
  parameter int OP_W   = 26,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int RA_W   = 5,
  parameter int CA_W   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [OP_W-1:0]       op_a,
  input  logic [OP_W-1:0]       op_b,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*OP_W-1:0]     DIN,
  output logic [RA_W-1:0]       RA,
  output logic [CA_W-1:0]       CA,
  output logic                  NCE,
  output logic                  NWRT,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       wr_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Two-entry input buffer
  logic [2*OP_W-1:0]   r_fifo [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_fifo_cnt;
  logic [1:0]          w_fifo_cnt_nxt;
  logic [CNT_W-1:0]    r_acc_cnt;
  logic [CNT_W-1:0]    w_acc_nxt;
  logic                w_push;
  logic                w_pop;

  // Next values of the registered outputs
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [CNT_W-1:0]    w_wr_count_nxt;
  logic [2*OP_W-1:0]   w_din_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_strobe_n_nxt;
  logic                w_in_ready_nxt;

  assign w_push = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and next-output decode; the write address is the running word count
  always_comb begin
    w_state_nxt    = r_state;
    w_busy_nxt     = busy;
    w_done_nxt     = done;
    w_wr_count_nxt = wr_count;
    w_acc_nxt      = r_acc_cnt + CNT_W'(w_push);
    w_din_nxt      = DIN;
    w_addr_nxt     = {RA, CA};
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt    = S_FETCH;
          w_busy_nxt     = 1'b1;
          w_done_nxt     = 1'b0;
          w_wr_count_nxt = '0;
          w_acc_nxt      = '0;
        end
      end
      S_FETCH: begin
        if (r_fifo_cnt != 2'd0) begin
          w_pop       = 1'b1;
          w_din_nxt   = r_fifo[r_rd_ptr];
          w_addr_nxt  = wr_count[ADDR_W-1:0];
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        w_wr_count_nxt = wr_count + CNT_W'(1);
        if (w_wr_count_nxt == C_DEPTH) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Both strobes fall together and only in STROBE, so no read is ever issued
    w_strobe_n_nxt = (w_state_nxt != S_STROBE);
    w_fifo_cnt_nxt = r_fifo_cnt + 2'(w_push) - 2'(w_pop);
    w_in_ready_nxt = w_busy_nxt && (w_fifo_cnt_nxt != 2'd2) && (w_acc_nxt < C_DEPTH);
  end

  // Buffer pointers, occupancy and per-run accepted count
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
      r_acc_cnt  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_fifo_cnt <= w_fifo_cnt_nxt;
      r_acc_cnt  <= w_acc_nxt;
    end
  end

  // Buffer storage; contents are don't-care while the occupancy is zero
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {op_a, op_b};
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      in_ready <= 1'b0;
      DIN      <= '0;
      RA       <= '0;
      CA       <= '0;
      NCE      <= 1'b1;
      NWRT     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_count <= '0;
    end else begin
      in_ready <= w_in_ready_nxt;
      DIN      <= w_din_nxt;
      RA       <= w_addr_nxt[ADDR_W-1:CA_W];
      CA       <= w_addr_nxt[CA_W-1:0];
      NCE      <= w_strobe_n_nxt;
      NWRT     <= w_strobe_n_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      wr_count <= w_wr_count_nxt;
    end
  end

endmodule

`default_nettype wire
